serial_tx: RTL and testbench
============================

// Module: serial_tx
// PURPOSE
//  Framed bit-serial transmitter: accepts a WIDTH-bit word on a valid/ready handshake, drives it onto one
//  line that an external d_ff-based receiver samples. Frame: start(0), WIDTH data bits LSB first, stop(1).
//  Sits between a parallel producer and the single-bit serial path; idle line level is 1.
// PARAMETERS
//  WIDTH         8  data bits per frame; must be >= 1
//  CLKS_PER_BIT  4  clk cycles each frame bit is held on sout; must be >= 1
// PORTS
//  clk        in   1      single clock; all state changes on posedge
//  n_rst      in   1      reset, synchronous, active-low (sampled on posedge clk)
//  data_in    in   WIDTH  word to transmit; sampled only on accept edge
//  valid_in   in   1      producer has a word
//  ready_out  out  1      transmitter can accept; accept = valid_in & ready_out at posedge
//  sout       out  1      serial line (registered)
//  busy       out  1      frame in progress (START/DATA/STOP)
// BEHAVIOUR
//  - Reset (n_rst==0 at posedge): state=IDLE, sout=1, ready_out=1, busy=0, shift reg/counters=0.
//    Reset mid-frame aborts the frame; sout returns to 1 on that same edge; no partial resume.
//  - States: IDLE -> START -> DATA -> STOP -> IDLE.
//  - IDLE: sout=1, ready_out=1, busy=0. On accept edge: latch data_in to shift reg, bit_cnt=0,
//    tick_cnt=0, go START. No accept -> stay IDLE.
//  - START: sout=0 for CLKS_PER_BIT cycles, then DATA.
//  - DATA: sout=shift[0]; each bit held CLKS_PER_BIT cycles; at end of bit shift right, bit_cnt+1;
//    after bit WIDTH-1 go STOP.
//  - STOP: sout=1 for CLKS_PER_BIT cycles, then IDLE.
//  - ready_out = (state==IDLE), busy = ~ready_out; both registered with state.
//  - Latency: first start-bit cycle on sout is the cycle immediately after the accept edge.
//  - Frame length exactly (WIDTH+2)*CLKS_PER_BIT cycles; ready_out low for exactly that many cycles.
//  - Back-to-back: valid_in held high gives min. one IDLE cycle (sout=1) between frames; throughput
//    one word per (WIDTH+2)*CLKS_PER_BIT+1 cycles.
//  - valid_in / data_in changes while busy are ignored; no buffering, no word dropped silently:
//    producer must hold valid_in until accepted.
//  - tick_cnt width $clog2(CLKS_PER_BIT) (min 1), wraps to 0 at CLKS_PER_BIT-1; bit_cnt width
//    $clog2(WIDTH+1); no counter ever exceeds its terminal value.
//  - CLKS_PER_BIT==1: one cycle per bit, tick counter constant 0, same state sequence.
//  - WIDTH<1 or CLKS_PER_BIT<1: elaboration error.
//  - No X on any output after first reset edge, regardless of data_in/valid_in X while busy.
// STRUCTURE
//  - Shared header serial_defs.vh: state encodings (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3),
//    LINE_IDLE=1'b1, START_BIT=1'b0, STOP_BIT=1'b1; reused by the matching receiver.
//  - One sub-module: bit_timer (CLKS_PER_BIT counter, clear input, one-cycle bit_done pulse at
//    terminal count, same clk/n_rst). Shift register, bit counter and FSM live in serial_tx.
// TESTING (WIDTH=8, CLKS_PER_BIT=4 unless stated)
//  1 Reset: n_rst=0 two edges, valid_in=1 -> sout=1, ready_out=1, busy=0; nothing accepted.
//  2 Single frame 8'hA5 -> sout per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1; ready_out low exactly 40
//    cycles, sout goes 0 the cycle after accept.
//  3 Back-to-back 8'h00 then 8'hFF, valid_in held -> two 40-cycle frames separated by exactly one
//    sout=1 idle cycle; second word sampled only on its own accept edge.
//  4 Change data_in to 8'h3C and pulse valid_in during frame of 8'hA5 -> transmitted bits remain
//    those of 8'hA5; 8'h3C never sent unless re-presented after ready_out returns.
//  5 n_rst=0 at cycle 15 of a frame -> sout=1, ready_out=1 from that edge; next frame of 8'h81 is
//    bit-exact: 0,1,0,0,0,0,0,0,1,1.
//  6 CLKS_PER_BIT=1, WIDTH=4, send 4'hC -> sout 0,0,0,1,1,1 on consecutive cycles; ready_out low 6.

Source files
------------

// File: rtl/serial_tx_pkg.sv
// Shared definitions for the framed serial link: FSM state encoding and line levels.
// The matching receiver imports the same package so both ends agree on framing.
package serial_tx_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } tx_state_e;

  localparam logic LineIdle = 1'b1;
  localparam logic StartBit = 1'b0;
  localparam logic StopBit  = 1'b1;

endpackage

// File: rtl/serial_tx_if.sv
// Parallel word handshake between a producer (master) and the serial transmitter (slave).
interface serial_tx_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             valid_in;
  logic             ready_out;

  modport master (output data_in, output valid_in, input ready_out);
  modport slave  (input data_in, input valid_in, output ready_out);
endinterface

// File: rtl/serial_tx_bit_timer.sv
// Bit-period timer: counts CLKS_PER_BIT cycles and pulses bit_done on the last one.
// Held at zero while clear is high so a new frame always starts on a full bit period.
module serial_tx_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  output logic bit_done
);
  localparam int unsigned TickW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TickW-1:0] TickMax = TickW'(CLKS_PER_BIT - 1);

  logic [TickW-1:0] tick_q, tick_d;

  always_comb begin
    bit_done = 1'b0;
    tick_d   = tick_q;
    if (clear) begin
      tick_d = '0;
    end else if (tick_q == TickMax) begin
      bit_done = 1'b1;
      tick_d   = '0;
    end else begin
      tick_d = tick_q + TickW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_d;
    end
  end

endmodule

// File: rtl/serial_tx.sv
// Framed bit-serial transmitter: start(0), WIDTH data bits LSB first, stop(1).
// One word per (WIDTH+2)*CLKS_PER_BIT+1 cycles at best; line idles high.
module serial_tx
  import serial_tx_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic         clk,
  input  logic         n_rst,
  serial_tx_if.slave   bus,
  output logic         sout,
  output logic         busy
);
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  if (WIDTH < 1 || CLKS_PER_BIT < 1) begin : g_bad_params
    $error("serial_tx: WIDTH and CLKS_PER_BIT must both be >= 1");
  end

  tx_state_e        state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic             sout_q, sout_d;
  logic             idle, accept, bit_done;

  assign idle          = (state_q == StIdle);
  assign accept        = bus.valid_in & idle;
  assign bus.ready_out = idle;
  assign busy          = ~idle;
  assign sout          = sout_q;

  serial_tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .n_rst   (n_rst),
    .clear   (idle),
    .bit_done(bit_done)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d   = StStart;
          shift_d   = bus.data_in;
          bit_cnt_d = '0;
        end
      end
      StStart: begin
        if (bit_done) state_d = StData;
      end
      StData: begin
        if (bit_done) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == CntW'(WIDTH - 1)) begin
            bit_cnt_d = '0;
            state_d   = StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + CntW'(1);
          end
        end
      end
      StStop: begin
        if (bit_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Line level follows the next state so sout changes on the same edge as the state.
    unique case (state_d)
      StStart: sout_d = StartBit;
      StData:  sout_d = shift_d[0];
      StStop:  sout_d = StopBit;
      default: sout_d = LineIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      sout_q    <= LineIdle;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      sout_q    <= sout_d;
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx: table vectors, directed corner sequences and random words
// compared against a frame model built from the framing rules.
module tb_serial_tx;

  logic clk = 1'b0;
  logic n_rst;
  logic sout8, busy8, sout4, busy4;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_tx_if #(.WIDTH(8)) bus8 ();
  serial_tx_if #(.WIDTH(4)) bus4 ();

  serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4)) dut8 (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus8),
    .sout (sout8),
    .busy (busy8)
  );

  serial_tx #(.WIDTH(4), .CLKS_PER_BIT(1)) dut4 (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus4),
    .sout (sout4),
    .busy (busy4)
  );

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // bit k = line level during frame bit k
    string      name;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, want);
    end
  endtask

  // Frame as a list of line levels: start, data LSB first, stop.
  function automatic logic [63:0] model_frame(input logic [63:0] w, input int width);
    bit q[$];
    logic [63:0] f;
    q.push_back(1'b0);
    for (int i = 0; i < width; i++) q.push_back(w[i]);
    q.push_back(1'b1);
    f = '0;
    foreach (q[k]) f[k] = q[k];
    return f;
  endfunction

  // Called at the first negedge after an accept edge; ends at the first idle negedge.
  task automatic capture_frame(input logic [9:0] exp, input string name);
    int n;
    int bad_busy;
    logic [39:0] got;
    logic [39:0] want;
    for (int k = 0; k < 40; k++) want[k] = exp[k / 4];
    got      = '0;
    n        = 0;
    bad_busy = 0;
    chk({name, "_latency"}, 64'(sout8), 64'(0));
    while (bus8.ready_out !== 1'b1 && n < 200) begin
      if (n < 40) got[n] = sout8;
      if (busy8 !== 1'b1) bad_busy++;
      n++;
      @(negedge clk);
    end
    chk({name, "_ready_low_cycles"}, 64'(n), 64'(40));
    chk({name, "_bits"}, 64'(got), 64'(want));
    chk({name, "_busy"}, 64'(bad_busy), 64'(0));
    chk({name, "_idle_sout"}, 64'(sout8), 64'(1));
  endtask

  task automatic run_frame(input logic [7:0] w, input logic [9:0] exp, input string name);
    @(negedge clk);
    bus8.data_in  = w;
    bus8.valid_in = 1'b1;
    @(negedge clk);
    bus8.valid_in = 1'b0;
    bus8.data_in  = 8'($urandom);
    capture_frame(exp, name);
  endtask

  task automatic run_frame4(input logic [3:0] w, input logic [5:0] exp, input string name);
    int n;
    logic [5:0] got;
    @(negedge clk);
    bus4.data_in  = w;
    bus4.valid_in = 1'b1;
    @(negedge clk);
    bus4.valid_in = 1'b0;
    bus4.data_in  = 4'($urandom);
    got = '0;
    n   = 0;
    chk({name, "_latency"}, 64'(sout4), 64'(0));
    while (bus4.ready_out !== 1'b1 && n < 50) begin
      if (n < 6) got[n] = sout4;
      n++;
      @(negedge clk);
    end
    chk({name, "_ready_low_cycles"}, 64'(n), 64'(6));
    chk({name, "_bits"}, 64'(got), 64'(exp));
    chk({name, "_idle_sout"}, 64'(sout4), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idle_busy;
    logic [7:0] w;
    logic [3:0] w4;

    vecs[0] = '{data: 8'hA5, frame: 10'b1101001010, name: "vec_a5"};
    vecs[1] = '{data: 8'h00, frame: 10'b1000000000, name: "vec_00"};
    vecs[2] = '{data: 8'hFF, frame: 10'b1111111110, name: "vec_ff"};
    vecs[3] = '{data: 8'h3C, frame: 10'b1001111000, name: "vec_3c"};
    vecs[4] = '{data: 8'h81, frame: 10'b1100000010, name: "vec_81"};

    // Reset held two edges with valid asserted.
    n_rst         = 1'b0;
    bus8.valid_in = 1'b1;
    bus8.data_in  = 8'h5A;
    bus4.valid_in = 1'b0;
    bus4.data_in  = 4'h0;
    for (int e = 0; e < 2; e++) begin
      @(negedge clk);
      chk("reset_sout", 64'(sout8), 64'(1));
      chk("reset_ready", 64'(bus8.ready_out), 64'(1));
      chk("reset_busy", 64'(busy8), 64'(0));
    end
    n_rst         = 1'b1;
    bus8.valid_in = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", 64'(bus8.ready_out), 64'(1));
    chk("post_reset_sout", 64'(sout8), 64'(1));
    chk("dut4_reset_ready", 64'(bus4.ready_out), 64'(1));

    // Table vectors.
    for (int i = 0; i < 5; i++) run_frame(vecs[i].data, vecs[i].frame, vecs[i].name);

    // Back-to-back with valid held: exactly one idle cycle between frames.
    @(negedge clk);
    bus8.data_in  = 8'h00;
    bus8.valid_in = 1'b1;
    @(negedge clk);
    bus8.data_in = 8'hFF;
    capture_frame(vecs[1].frame, "b2b_first");
    @(negedge clk);
    bus8.valid_in = 1'b0;
    bus8.data_in  = 8'h5A;
    capture_frame(vecs[2].frame, "b2b_second");

    // Input changes during a frame are ignored.
    @(negedge clk);
    bus8.data_in  = 8'hA5;
    bus8.valid_in = 1'b1;
    @(negedge clk);
    bus8.valid_in = 1'b0;
    fork
      capture_frame(vecs[0].frame, "ignore_busy");
      begin
        repeat (8) @(negedge clk);
        bus8.data_in  = 8'h3C;
        bus8.valid_in = 1'b1;
        repeat (3) @(negedge clk);
        bus8.valid_in = 1'b0;
      end
    join
    idle_busy = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus8.ready_out !== 1'b1) idle_busy++;
    end
    chk("ignore_busy_no_resend", 64'(idle_busy), 64'(0));

    // Reset mid-frame, then a clean frame.
    @(negedge clk);
    bus8.data_in  = 8'hA5;
    bus8.valid_in = 1'b1;
    @(negedge clk);
    bus8.valid_in = 1'b0;
    repeat (14) @(negedge clk);
    chk("midreset_busy_before", 64'(busy8), 64'(1));
    n_rst = 1'b0;
    @(negedge clk);
    chk("midreset_sout", 64'(sout8), 64'(1));
    chk("midreset_ready", 64'(bus8.ready_out), 64'(1));
    chk("midreset_busy", 64'(busy8), 64'(0));
    n_rst = 1'b1;
    run_frame(vecs[4].data, vecs[4].frame, "after_reset_81");

    // Random words against the model.
    for (int i = 0; i < 12; i++) begin
      w = 8'($urandom);
      run_frame(w, 10'(model_frame(64'(w), 8)), "rand8");
    end

    // One clock per bit, 4-bit words.
    run_frame4(4'hC, 6'b111000, "cpb1_c");
    for (int i = 0; i < 6; i++) begin
      w4 = 4'($urandom_range(15, 0));
      run_frame4(w4, 6'(model_frame(64'(w4), 4)), "rand4");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
